// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner: one shared segment bus, one-hot
// digit selects, a blanking gap at the start of every slot, and frame-aligned data capture.
module seg7_scan #(
    parameter int CLK_HZ       = 27000000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 27,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter bit LZ_BLANK     = 1'b0
) (
    input  logic        clkIn,
    input  logic        resetIn,
    input  logic        enableIn,
    input  logic [15:0] digitsIn,
    input  logic [3:0]  dpIn,
    output logic [6:0]  segOut,
    output logic        dpOut,
    output logic [3:0]  digitSelOut,
    output logic        frameOut
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    // Pin levels that mean "off" in the configured polarity
    localparam logic [6:0] SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [3:0] SEL_OFF = {4{ACTIVE_LOW}};
    localparam logic       DP_OFF  = ACTIVE_LOW;

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             slot_end;
    logic             frame_end;
    logic             in_blank;
    phase_t           phase;

    logic [3:0][3:0]  shadow_dig;
    logic [3:0]       shadow_dp;
    logic [3:0]       lz_sup;
    logic [3:0]       cur_dig;

    logic [6:0]       seg_nxt;
    logic [3:0]       sel_nxt;
    logic             dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture only at the frame boundary so a frame never mixes old and new data
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            frameOut   <= 1'b0;
        end else begin
            frameOut <= frame_end;
            if (frame_end) begin
                shadow_dig <= digitsIn;
                shadow_dp  <= dpIn;
            end
        end
    end

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));
        end else begin : g_noblank
            assign in_blank = 1'b0;
        end
    endgenerate

    assign phase = in_blank ? PH_BLANK : PH_SHOW;

    // A digit is a leading zero when it and everything above it are zero
    always_comb begin
        lz_sup    = '0;
        lz_sup[3] = (shadow_dig[3] == 4'h0);
        lz_sup[2] = lz_sup[3] && (shadow_dig[2] == 4'h0);
        lz_sup[1] = lz_sup[2] && (shadow_dig[1] == 4'h0);
        if (!LZ_BLANK)
            lz_sup = '0;
    end

    assign cur_dig = shadow_dig[idx];

    always_comb begin
        sel_nxt = '0;
        seg_nxt = '0;
        dp_nxt  = 1'b0;
        if (enableIn && phase == PH_SHOW) begin
            dp_nxt = shadow_dp[idx];
            if (!lz_sup[idx]) begin
                sel_nxt = 4'b0001 << idx;
                seg_nxt = decode(cur_dig);
            end
        end
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            segOut      <= SEG_OFF;
            digitSelOut <= SEL_OFF;
            dpOut       <= DP_OFF;
        end else begin
            segOut      <= seg_nxt ^ SEG_OFF;
            digitSelOut <= sel_nxt ^ SEL_OFF;
            dpOut       <= dp_nxt ^ DP_OFF;
        end
    end

endmodule
